// File: rtl/chain_request_initiator_pkg.sv
// Shared packet, status and FSM encodings for the daisy-chain request ring.
// Packet layout is {type, payload}; a REQ payload is {node_id, cmd}.
package chain_request_initiator_pkg;

  localparam int unsigned TYPE_CODE_W = 2;
  localparam int unsigned STATUS_W    = 2;

  localparam logic [TYPE_CODE_W-1:0] TYPE_IDLE = 2'd0;
  localparam logic [TYPE_CODE_W-1:0] TYPE_REQ  = 2'd1;
  localparam logic [TYPE_CODE_W-1:0] TYPE_RESP = 2'd2;

  localparam logic [STATUS_W-1:0] STATUS_OK      = 2'd0;
  localparam logic [STATUS_W-1:0] STATUS_MISS    = 2'd1;
  localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/chain_request_initiator_timeout.sv
// chain_timeout_counter: saturating WAIT-cycle counter with a one-cycle expiry flag.
// TIMEOUT_CYCLES of 0 disables expiry entirely.
module chain_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit EXPIRE_EN = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the last counted cycle so DONE is entered exactly TIMEOUT_CYCLES after WAIT entry.
  assign expire_c = EXPIRE_EN && enable && (count_q == CNT_LAST);

endmodule

// File: rtl/chain_request_initiator.sv
// Initiator of the daisy-chain request ring: launches one REQ, waits for it to
// return as RESP (OK), unchanged REQ (MISS) or not at all (TIMEOUT).
module chain_request_initiator
  import chain_request_initiator_pkg::*;
#(
  parameter int unsigned TYPE_W         = 2,
  parameter int unsigned PAYLOAD_W      = 32,
  parameter int unsigned ID_W           = 4,
  parameter int unsigned CMD_W          = PAYLOAD_W - ID_W,
  parameter int unsigned PKT_W          = TYPE_W + PAYLOAD_W,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ID_W-1:0]      req_node_id,
  input  logic [CMD_W-1:0]     req_cmd,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_status,
  output logic [PAYLOAD_W-1:0] resp_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [PKT_W-1:0]     tx_packet,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [PKT_W-1:0]     rx_packet,
  output logic                 stray_pulse
);

  state_e state_q, state_d;

  logic [PAYLOAD_W-1:0] pend_q, pend_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [PKT_W-1:0]     tx_packet_q, tx_packet_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [1:0]           resp_status_q, resp_status_d;
  logic [PAYLOAD_W-1:0] resp_data_q, resp_data_d;
  logic                 stray_q, stray_d;

  logic [TYPE_W-1:0]    rx_type_c;
  logic [PAYLOAD_W-1:0] rx_payload_c;
  logic                 rx_resp_c, rx_miss_c, rx_term_c;
  logic                 accept_c, timer_clear_c, timer_en_c, expire_c;

  // Packet field split and rx classification against the pending request.
  assign rx_type_c    = rx_packet[PKT_W-1 -: TYPE_W];
  assign rx_payload_c = rx_packet[PAYLOAD_W-1:0];
  assign rx_resp_c    = rx_valid && (rx_type_c == TYPE_W'(TYPE_RESP));
  assign rx_miss_c    = rx_valid && (rx_type_c == TYPE_W'(TYPE_REQ)) && (rx_payload_c == pend_q);
  assign rx_term_c    = rx_resp_c || rx_miss_c;

  assign req_ready     = (state_q == ST_IDLE) && !rst;
  assign accept_c      = req_valid && req_ready;
  assign timer_clear_c = (state_q == ST_SEND) && tx_ready;
  assign timer_en_c    = (state_q == ST_WAIT);
  assign rx_ready      = 1'b1;

  chain_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear_c),
    .enable   (timer_en_c),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)                state_d = ST_SEND;
      ST_SEND: if (tx_ready)                state_d = ST_WAIT;
      ST_WAIT: if (rx_term_c || expire_c)   state_d = ST_DONE;
      ST_DONE: if (resp_ready)              state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_d        = pend_q;
    tx_valid_d    = tx_valid_q;
    tx_packet_d   = tx_packet_q;
    resp_valid_d  = resp_valid_q;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    // Every rx packet that does not terminate a WAIT is dropped and flagged.
    stray_d       = rx_valid && !((state_q == ST_WAIT) && rx_term_c);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          pend_d      = {req_node_id, req_cmd};
          tx_valid_d  = 1'b1;
          tx_packet_d = {TYPE_W'(TYPE_REQ), req_node_id, req_cmd};
        end
      end
      ST_SEND: begin
        if (tx_ready) tx_valid_d = 1'b0;
      end
      ST_WAIT: begin
        if (rx_resp_c) begin
          resp_valid_d  = 1'b1;
          resp_status_d = STATUS_OK;
          resp_data_d   = rx_payload_c;
        end else if (rx_miss_c) begin
          resp_valid_d  = 1'b1;
          resp_status_d = STATUS_MISS;
          resp_data_d   = '0;
        end else if (expire_c) begin
          resp_valid_d  = 1'b1;
          resp_status_d = STATUS_TIMEOUT;
          resp_data_d   = '0;
        end
      end
      ST_DONE: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q        <= '0;
      tx_valid_q    <= 1'b0;
      tx_packet_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_data_q   <= '0;
      stray_q       <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      tx_valid_q    <= tx_valid_d;
      tx_packet_q   <= tx_packet_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
      stray_q       <= stray_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_packet   = tx_packet_q;
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_data   = resp_data_q;
  assign stray_pulse = stray_q;

endmodule

// File: tb/tb_chain_request_initiator.sv
// Self-checking bench for chain_request_initiator: table-driven transactions
// with a response scoreboard, plus hand-written timeout/stray/hold/reset sequences.
module tb_chain_request_initiator;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_REQ  = 2'd1;
  localparam logic [1:0] T_RESP = 2'd2;
  localparam logic [1:0] S_OK   = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_TO   = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_node_id = '0;
  logic [27:0] req_cmd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [33:0] tx_packet;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [33:0] rx_packet = '0;
  logic        stray_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] sb[$];

  always #5 clk = ~clk;

  chain_request_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_node_id(req_node_id), .req_cmd(req_cmd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_data(resp_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_packet(tx_packet),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_packet(rx_packet),
    .stray_pulse(stray_pulse)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a response handshake pops the oldest expected {status, data}.
  always begin
    logic [33:0] e;
    @(posedge clk);
    #2;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got status %0d data %0h expected no response", resp_status, resp_data);
      end else begin
        e = sb.pop_front();
        chk("resp_status", 64'(resp_status), 64'(e[33:32]));
        chk("resp_data", 64'(resp_data), 64'(e[31:0]));
      end
    end
  end

  task automatic send_req(input logic [3:0] id, input logic [27:0] cmd, input int stall);
    int n;
    logic [33:0] exp_pkt;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    exp_pkt = {T_REQ, id, cmd};
    req_valid = 1'b1; req_node_id = id; req_cmd = cmd;
    step();
    req_valid = 1'b0;
    chk("tx_valid_latency", 64'(tx_valid), 64'd1);
    chk("tx_packet", 64'(tx_packet), 64'(exp_pkt));
    for (int i = 0; i < stall; i++) begin
      step();
      chk("tx_hold_valid", 64'(tx_valid), 64'd1);
      chk("tx_hold_packet", 64'(tx_packet), 64'(exp_pkt));
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx_valid_after_hs", 64'(tx_valid), 64'd0);
  endtask

  task automatic drive_rx(input logic [33:0] pkt);
    rx_valid = 1'b1; rx_packet = pkt;
    step();
    rx_valid = 1'b0; rx_packet = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 40) begin step(); n++; end
    chk("drain_to_idle", 64'(n < 40), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [27:0] cmd;
    int          stall;
    int          delay;
    bit          loop_back;
    logic [31:0] rx_data;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vec[6];

  task automatic run_txn(input vec_t v);
    logic [33:0] pkt;
    send_req(v.id, v.cmd, v.stall);
    repeat (v.delay) step();
    pkt = v.loop_back ? {T_REQ, v.id, v.cmd} : {T_RESP, v.rx_data};
    sb.push_back({v.exp_status, v.exp_data});
    drive_rx(pkt);
    chk("resp_valid_latency", 64'(resp_valid), 64'd1);
    wait_idle();
  endtask

  initial begin
    int first;
    logic stray_at;
    logic seen;

    vec[0] = '{4'h3, 28'h0000123, 0, 5,  1'b0, 32'hDEADBEEF, S_OK,   32'hDEADBEEF};
    vec[1] = '{4'h3, 28'h0000123, 0, 5,  1'b1, 32'h0,        S_MISS, 32'h0};
    vec[2] = '{4'hF, 28'hFFFFFFF, 0, 0,  1'b0, 32'h0,        S_OK,   32'h0};
    vec[3] = '{4'h0, 28'h0000000, 0, 15, 1'b0, 32'h12345678, S_OK,   32'h12345678};
    vec[4] = '{4'hA, 28'h5A5A5A5, 0, 15, 1'b1, 32'h0,        S_MISS, 32'h0};
    vec[5] = '{4'h1, 28'h0000001, 2, 1,  1'b0, 32'hCAFEF00D, S_OK,   32'hCAFEF00D};

    // Reset state
    repeat (3) step();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_packet", 64'(tx_packet), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_status", 64'(resp_status), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_stray", 64'(stray_pulse), 64'd0);
    chk("rx_ready", 64'(rx_ready), 64'd1);
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", 64'(req_ready), 64'd1);

    for (int i = 0; i < 6; i++) run_txn(vec[i]);

    // Timeout after a 7-cycle tx stall, with a stray arriving on the expiry cycle
    send_req(4'h2, 28'h0000077, 7);
    sb.push_back({S_TO, 32'h0});
    first = -1;
    stray_at = 1'b0;
    for (int c = 0; c < 30 && first < 0; c++) begin
      if (c == 15) begin rx_valid = 1'b1; rx_packet = {T_IDLE, 32'h0}; end
      step();
      rx_valid = 1'b0; rx_packet = '0;
      if (resp_valid) begin first = c + 1; stray_at = stray_pulse; end
    end
    chk("timeout_latency", 64'(first), 64'd16);
    chk("stray_with_expiry", 64'(stray_at), 64'd1);
    step();
    drive_rx({T_RESP, 32'hDEADBEEF});
    chk("late_resp_stray", 64'(stray_pulse), 64'd1);
    seen = 1'b0;
    repeat (5) begin step(); if (resp_valid) seen = 1'b1; end
    chk("no_second_resp", 64'(seen), 64'd0);
    wait_idle();

    // Strays inside WAIT, then the real response
    send_req(4'h5, 28'h0000042, 0);
    rx_valid = 1'b1; rx_packet = {T_IDLE, 32'h0};
    step();
    chk("stray_idle_pkt", 64'(stray_pulse), 64'd1);
    rx_packet = {T_REQ, 4'h6, 28'h0000042};
    step();
    chk("stray_other_req", 64'(stray_pulse), 64'd1);
    sb.push_back({S_OK, 32'h0BADF00D});
    rx_packet = {T_RESP, 32'h0BADF00D};
    step();
    rx_valid = 1'b0; rx_packet = '0;
    chk("resp_no_stray", 64'(stray_pulse), 64'd0);
    chk("resp_after_strays", 64'(resp_valid), 64'd1);
    wait_idle();

    // Response held while resp_ready is low
    resp_ready = 1'b0;
    send_req(4'h7, 28'h0000099, 0);
    sb.push_back({S_OK, 32'h11223344});
    drive_rx({T_RESP, 32'h11223344});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_resp_valid", 64'(resp_valid), 64'd1);
      chk("hold_resp_data", 64'(resp_data), 64'h11223344);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("resp_dropped", 64'(resp_valid), 64'd0);
    chk("req_ready_after_accept", 64'(req_ready), 64'd1);
    wait_idle();

    // Reset while waiting; the returning packet is stray and a new request completes
    send_req(4'h9, 28'h0000003, 0);
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midrst_tx_packet", 64'(tx_packet), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_resp_data", 64'(resp_data), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready_release", 64'(req_ready), 64'd1);
    drive_rx({T_REQ, 4'h9, 28'h0000003});
    chk("post_rst_stray", 64'(stray_pulse), 64'd1);
    run_txn(vec[0]);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
